high_speed_in_bus: RTL and testbench

HIGH_SPEED_IN_BUS -- requirements
Module: high_speed_in_bus

---
 rtl/high_speed_in_bus.sv | 182 ++++++++++++++++++
 tb/tb_high_speed_in_bus.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/high_speed_in_bus.sv
// high_speed_in_bus: receives HIGH_SPEED_IN_PINS-wide chunks from an asynchronous
// transmitter over a request/acknowledge handshake. It assembles CHUNKS_PER_WORD
// chunks into one word and offers each word to the core over a valid/ready handshake.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   start, num_words    begin a transaction of num_words words (sampled on start)
//   request, in         transmitter request (synchronized here) and chunk data
//   acknowledge         registered handshake acknowledge to the transmitter
//   out, out_valid,     assembled word and its handshake to the core
//   out_ready
//   word_counter        words completed in the current transaction
//   done_receiving      level, high once the transaction is complete
//   parity,             only when HIGH_SPEED_IN_BUS_PARITY_EN is defined:
//   parity_error        even parity over in; sticky mismatch flag until start or reset
module high_speed_in_bus #(
    parameter int unsigned HIGH_SPEED_IN_PINS     = 8,
    parameter int unsigned CHUNKS_PER_WORD        = 4,
    parameter int unsigned WORD_COUNTER_BIT_WIDTH = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [WORD_COUNTER_BIT_WIDTH-1:0]             num_words,
    input  logic                                          request,
    input  logic [HIGH_SPEED_IN_PINS-1:0]                 in,
`ifdef HIGH_SPEED_IN_BUS_PARITY_EN
    input  logic                                          parity,
    output logic                                          parity_error,
`endif
    output logic                                          acknowledge,
    output logic [HIGH_SPEED_IN_PINS*CHUNKS_PER_WORD-1:0] out,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [WORD_COUNTER_BIT_WIDTH-1:0]             word_counter,
    output logic                                          done_receiving
);

    localparam int unsigned PINS   = HIGH_SPEED_IN_PINS;
    localparam int unsigned WORD_W = HIGH_SPEED_IN_PINS * CHUNKS_PER_WORD;
    localparam int unsigned WCW    = WORD_COUNTER_BIT_WIDTH;
    localparam int unsigned CIDX_W = (CHUNKS_PER_WORD > 1) ? $clog2(CHUNKS_PER_WORD) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_REQ, WAIT_REL, DONE} state_t;

    state_t              state_q, state_d;
    logic                req_meta_q, req_meta_d;
    logic                req_sync_q, req_sync_d;
    logic                ack_q, ack_d;
    logic [WORD_W-1:0]   chunk_buf_q, chunk_buf_d;
    logic [WORD_W-1:0]   out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic [WCW-1:0]      word_cnt_q, word_cnt_d;
    logic [WCW-1:0]      num_words_q, num_words_d;
    logic [CIDX_W-1:0]   chunk_idx_q, chunk_idx_d;
    logic                done_q, done_d;
    logic                is_last_c;
    logic                cap_block_c;
    logic                capture_c;
`ifdef HIGH_SPEED_IN_BUS_PARITY_EN
    logic                perr_q, perr_d;
`endif

    // Next-state, datapath and handshake logic
    always_comb begin
        state_d     = state_q;
        req_meta_d  = request;
        req_sync_d  = req_meta_q;
        ack_d       = ack_q;
        chunk_buf_d = chunk_buf_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        word_cnt_d  = word_cnt_q;
        num_words_d = num_words_q;
        chunk_idx_d = chunk_idx_q;
        capture_c   = 1'b0;
`ifdef HIGH_SPEED_IN_BUS_PARITY_EN
        perr_d      = perr_q;
`endif

        is_last_c   = (chunk_idx_q == CIDX_W'(CHUNKS_PER_WORD - 1));
        // The last chunk would overwrite a word the core has not taken yet
        cap_block_c = is_last_c && out_valid_q && !out_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    num_words_d = num_words;
                    word_cnt_d  = '0;
                    chunk_idx_d = '0;
                    state_d     = (num_words == '0) ? DONE : WAIT_REQ;
`ifdef HIGH_SPEED_IN_BUS_PARITY_EN
                    perr_d      = 1'b0;
`endif
                end
            end
            WAIT_REQ: begin
                if (req_sync_q && !cap_block_c) begin
                    capture_c = 1'b1;
                    ack_d     = 1'b1;
                    state_d   = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!req_sync_q) begin
                    ack_d   = 1'b0;
                    state_d = (word_cnt_q == num_words_q) ? DONE : WAIT_REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture_c) begin
            chunk_buf_d[int'(chunk_idx_q)*PINS +: PINS] = in;
`ifdef HIGH_SPEED_IN_BUS_PARITY_EN
            if ((^in) != parity) begin
                perr_d = 1'b1;
            end
`endif
            if (is_last_c) begin
                // A newly loaded word wins over a simultaneous consume
                out_d       = chunk_buf_d;
                out_valid_d = 1'b1;
                word_cnt_d  = word_cnt_q + WCW'(1);
                chunk_idx_d = '0;
            end else begin
                chunk_idx_d = chunk_idx_q + CIDX_W'(1);
            end
        end

        done_d = (state_d == DONE);
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_meta_q  <= 1'b0;
            req_sync_q  <= 1'b0;
            ack_q       <= 1'b0;
            chunk_buf_q <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            word_cnt_q  <= '0;
            num_words_q <= '0;
            chunk_idx_q <= '0;
            done_q      <= 1'b0;
`ifdef HIGH_SPEED_IN_BUS_PARITY_EN
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_meta_q  <= req_meta_d;
            req_sync_q  <= req_sync_d;
            ack_q       <= ack_d;
            chunk_buf_q <= chunk_buf_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            word_cnt_q  <= word_cnt_d;
            num_words_q <= num_words_d;
            chunk_idx_q <= chunk_idx_d;
            done_q      <= done_d;
`ifdef HIGH_SPEED_IN_BUS_PARITY_EN
            perr_q      <= perr_d;
`endif
        end
    end

    assign acknowledge    = ack_q;
    assign out            = out_q;
    assign out_valid      = out_valid_q;
    assign word_counter   = word_cnt_q;
    assign done_receiving = done_q;
`ifdef HIGH_SPEED_IN_BUS_PARITY_EN
    assign parity_error   = perr_q;
`endif

endmodule

// File: tb/tb_high_speed_in_bus.sv
// Bench for high_speed_in_bus: a transmitter model drives the four-phase handshake,
// the expected words are built from the chunks sent, and a monitor logs every word
// the core accepts and every acknowledge pulse.
module tb_high_speed_in_bus;

    localparam int unsigned P  = 8;
    localparam int unsigned C  = 4;
    localparam int unsigned WC = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [WC-1:0]   num_words = '0;
    logic            request = 1'b0;
    logic [P-1:0]    in_data = '0;
    logic            parity = 1'b0;
    logic            acknowledge;
    logic [P*C-1:0]  out;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [WC-1:0]   word_counter;
    logic            done_receiving;
`ifdef HIGH_SPEED_IN_BUS_PARITY_EN
    logic            parity_error;
`endif

    high_speed_in_bus #(
        .HIGH_SPEED_IN_PINS(P), .CHUNKS_PER_WORD(C), .WORD_COUNTER_BIT_WIDTH(WC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .request(request), .in(in_data),
`ifdef HIGH_SPEED_IN_BUS_PARITY_EN
        .parity(parity), .parity_error(parity_error),
`endif
        .acknowledge(acknowledge), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .word_counter(word_counter),
        .done_receiving(done_receiving)
    );

    always #5 clk = ~clk;

    // out_ready changes just after the rising edge so it is stable at the falling edge
    bit   rdy_rand = 1'b0;
    logic rdy_val  = 1'b0;
    always begin
        @(posedge clk);
        #1;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end

    // Monitor: words accepted by the core and acknowledge rising edges
    logic [P*C-1:0] obs [1024];
    int             obs_n = 0;
    int             ack_pulses = 0;
    logic           ack_prev = 1'b0;
    always @(negedge clk) begin
        if (rst && out_valid && out_ready && obs_n < 1024) begin
            obs[obs_n] = out;
            obs_n++;
        end
        if (acknowledge && !ack_prev) ack_pulses++;
        ack_prev = acknowledge;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_start(input logic [WC-1:0] nw);
        @(negedge clk);
        start = 1'b1;
        num_words = nw;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ack_low();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!acknowledge) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("ack_fall", 64'(ok), 64'd1);
    endtask

    // One full four-phase handshake for one chunk
    task automatic send_chunk(input logic [P-1:0] d, input bit flip);
        bit ok = 1'b0;
        @(negedge clk);
        in_data = d;
        parity  = (^d) ^ flip;
        request = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (acknowledge) begin ok = 1'b1; break; end
        end
        request = 1'b0;
        check("ack_rise", 64'(ok), 64'd1);
        wait_ack_low();
    endtask

    // Full transaction against the reference model (word = sum of chunk << 8k)
    task automatic run_txn(input logic [WC-1:0] nw, input bit rnd, input bit glitch,
                           input logic [WC-1:0] exp_wc, input bit fixed);
        logic [P*C-1:0] exp_w [16];
        logic [P-1:0]   d;
        int             base, acks0;
        rdy_rand = rnd;
        rdy_val  = 1'b1;
        base  = obs_n;
        acks0 = ack_pulses;
        do_start(nw);
        for (int w = 0; w < int'(nw); w++) begin
            exp_w[w] = '0;
            for (int k = 0; k < int'(C); k++) begin
                d = fixed ? P'((w * int'(C) + k + 1) * 17) : P'($urandom);
                exp_w[w] = exp_w[w] | ((P*C)'(d) << (P * k));
                send_chunk(d, 1'b0);
                if (glitch && w == 0 && k == 0) do_start(WC'(1));
            end
        end
        rdy_rand = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (obs_n - base >= int'(nw)) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("words_seen", 64'(obs_n - base), 64'(nw));
        for (int w = 0; w < int'(nw); w++) check("word", 64'(obs[base + w]), 64'(exp_w[w]));
        check("word_counter", 64'(word_counter), 64'(exp_wc));
        check("done_receiving", 64'(done_receiving), 64'd1);
        check("ack_pulses", 64'(ack_pulses - acks0), 64'(int'(nw) * int'(C)));
    endtask

    typedef struct {
        logic [WC-1:0] nw;
        bit            rnd;
        bit            glitch;
        logic [WC-1:0] exp_wc;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   base, acks0, cyc;
        bit   ok;

        vecs[0] = '{nw: 4'd1,  rnd: 1'b0, glitch: 1'b0, exp_wc: 4'd1};
        vecs[1] = '{nw: 4'd3,  rnd: 1'b1, glitch: 1'b0, exp_wc: 4'd3};
        vecs[2] = '{nw: 4'd2,  rnd: 1'b1, glitch: 1'b1, exp_wc: 4'd2};
        vecs[3] = '{nw: 4'd5,  rnd: 1'b0, glitch: 1'b1, exp_wc: 4'd5};
        vecs[4] = '{nw: 4'd4,  rnd: 1'b1, glitch: 1'b0, exp_wc: 4'd4};
        vecs[5] = '{nw: 4'd15, rnd: 1'b1, glitch: 1'b0, exp_wc: 4'd15};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ack", 64'(acknowledge), 64'd0);
        check("rst_out", 64'(out), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_word_counter", 64'(word_counter), 64'd0);
        check("rst_done", 64'(done_receiving), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Two words of 0x11..0x88 with the core always ready
        base = obs_n;
        run_txn(4'd2, 1'b0, 1'b0, 4'd2, 1'b1);
        check("fixed_word0", 64'(obs[base]), 64'h44332211);
        check("fixed_word1", 64'(obs[base + 1]), 64'h88776655);

        // Zero words: straight to DONE, a held request is never acknowledged
        do_start(4'd0);
        check("zero_done", 64'(done_receiving), 64'd1);
        check("zero_word_counter", 64'(word_counter), 64'd0);
        acks0 = ack_pulses;
        in_data = 8'h5a;
        request = 1'b1;
        repeat (20) @(negedge clk);
        check("zero_no_ack", 64'(ack_pulses - acks0), 64'd0);
        request = 1'b0;
        repeat (3) @(negedge clk);

        // Core stalls: last chunk of word 2 waits for room
        rdy_rand = 1'b0;
        rdy_val  = 1'b0;
        repeat (2) @(negedge clk);
        base = obs_n;
        do_start(4'd2);
        send_chunk(8'h11, 1'b0); send_chunk(8'h22, 1'b0);
        send_chunk(8'h33, 1'b0); send_chunk(8'h44, 1'b0);
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_out", 64'(out), 64'h44332211);
        send_chunk(8'h55, 1'b0); send_chunk(8'h66, 1'b0); send_chunk(8'h77, 1'b0);
        @(negedge clk);
        in_data = 8'h88;
        parity  = ^in_data;
        request = 1'b1;
        acks0 = ack_pulses;
        repeat (10) @(negedge clk);
        check("stall_no_ack", 64'(ack_pulses - acks0), 64'd0);
        rdy_val = 1'b1;
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (acknowledge) begin ok = 1'b1; cyc = i + 1; break; end
        end
        check("stall_ack_after_ready", 64'(ok && cyc <= 2), 64'd1);
        request = 1'b0;
        wait_ack_low();
        repeat (3) @(negedge clk);
        check("stall_words_seen", 64'(obs_n - base), 64'd2);
        check("stall_word0", 64'(obs[base]), 64'h44332211);
        check("stall_word1", 64'(obs[base + 1]), 64'h88776655);
        check("stall_word_counter", 64'(word_counter), 64'd2);
        check("stall_done", 64'(done_receiving), 64'd1);

        // Reset while the acknowledge is held high
        rdy_val = 1'b0;
        repeat (2) @(negedge clk);
        do_start(4'd2);
        for (int k = 0; k < int'(C); k++) send_chunk(P'($urandom), 1'b0);
        check("pre_rst_word_counter", 64'(word_counter), 64'd1);
        @(negedge clk);
        in_data = 8'hc3;
        parity  = ^in_data;
        request = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acknowledge) begin ok = 1'b1; break; end
        end
        check("pre_rst_ack", 64'(ok), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("midrst_ack", 64'(acknowledge), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_word_counter", 64'(word_counter), 64'd0);
        request = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run_txn(4'd2, 1'b0, 1'b0, 4'd2, 1'b0);

        // Randomized transactions from the table
        foreach (vecs[i]) run_txn(vecs[i].nw, vecs[i].rnd, vecs[i].glitch, vecs[i].exp_wc, 1'b0);

`ifdef HIGH_SPEED_IN_BUS_PARITY_EN
        // Bad parity is flagged, data still assembled, cleared by the next start
        rdy_val = 1'b1;
        base = obs_n;
        do_start(4'd1);
        send_chunk(8'h01, 1'b1);
        check("parity_error_set", 64'(parity_error), 64'd1);
        send_chunk(8'h02, 1'b0); send_chunk(8'h03, 1'b0); send_chunk(8'h04, 1'b0);
        repeat (3) @(negedge clk);
        check("parity_word", 64'(obs[base]), 64'h04030201);
        check("parity_error_sticky", 64'(parity_error), 64'd1);
        do_start(4'd0);
        check("parity_error_clear", 64'(parity_error), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
